display_mux: RTL

//  Time-multiplexes a 16-bit hex value across the Basys2 4-digit 7-segment display.

---
 rtl/display_mux.sv | 98 +++++++++
 1 files changed

// File: rtl/display_mux.sv
`default_nettype none
// ============================================================================
// Module      : display_mux
// Description : Time-multiplexed driver for a 4-digit 7-segment display.
//               Holds a 16-bit hex value and 4 decimal-point bits in a
//               load-strobed register and scans the digits at a fixed
//               refresh rate. It drives the active digit's nibble to the
//               segment decoder, plus active-low anodes and decimal point.
//               Optional macro LEADING_ZERO_BLANK_EN auto-blanks leading
//               zero digits 3..1.
// Revision    : 1.0 - initial release
// ============================================================================
module display_mux #(
  parameter int CLKS_PER_DIGIT = 12500,
  parameter int CNT_W          = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank,
  output logic [3:0]  decision,
  output logic [3:0]  anode,
  output logic        dp_n,
  output logic        frame_start
);

  localparam logic [CNT_W-1:0] c_TICK_LAST = CNT_W'(CLKS_PER_DIGIT - 1);

  logic [15:0]      r_value;
  logic [3:0]       r_dp;
  logic [CNT_W-1:0] r_tick;
  logic [1:0]       r_idx;
  // Low for the first cycle after reset so digit 0 gets a full first slot
  // and is the first digit shown, whatever CLKS_PER_DIGIT is.
  logic             r_run;

  logic             w_advance;
  logic [1:0]       w_idx_next;
  logic [CNT_W-1:0] w_tick_next;
  logic [3:0]       w_auto_blank;
  logic [3:0]       w_blank;

  // Refresh counter next-state and digit advance decision.
  always_comb begin
    w_advance   = r_run && (r_tick == c_TICK_LAST);
    w_idx_next  = w_advance ? (r_idx + 2'd1) : r_idx;
    w_tick_next = r_tick;
    if (r_run) begin
      w_tick_next = (r_tick == c_TICK_LAST) ? '0 : (r_tick + 1'b1);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every higher nibble are zero.
  // Digit 0 is always shown so a zero value still displays "0".
  assign w_auto_blank = {(r_value[15:12] == 4'h0),
                         (r_value[15:8]  == 8'h00),
                         (r_value[15:4]  == 12'h000),
                         1'b0};
`else
  assign w_auto_blank = 4'b0000;
`endif

  assign w_blank = blank | w_auto_blank;

  // Hold register, scan state and registered display outputs. Outputs are
  // built from the next digit index but the current held value, so a load
  // coinciding with a digit advance shows up one cycle after the advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_value     <= 16'h0000;
      r_dp        <= 4'b0000;
      r_tick      <= '0;
      r_idx       <= 2'd0;
      r_run       <= 1'b0;
      decision    <= 4'h0;
      anode       <= 4'b1111;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      r_run  <= 1'b1;
      r_tick <= w_tick_next;
      r_idx  <= w_idx_next;
      if (load) begin
        r_value <= value;
        r_dp    <= dp_in;
      end
      decision    <= r_value[{w_idx_next, 2'b00} +: 4];
      anode       <= w_blank[w_idx_next] ? 4'b1111 : ~(4'b0001 << w_idx_next);
      dp_n        <= w_blank[w_idx_next] | ~r_dp[w_idx_next];
      frame_start <= w_advance && (r_idx == 2'd3);
    end
  end

endmodule
`default_nettype wire
